// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 receive path
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_PARITY = 3'd2,
    ST_STOP   = 3'd3,
    ST_HOLD   = 3'd4
  } ps2_state_e;

  localparam int ENTRY_W  = 10;
  localparam int DATA_LSB = 0;
  localparam int DATA_MSB = 7;
  localparam int PERR_BIT = 8;
  localparam int FERR_BIT = 9;

  // XOR of the eight data bits and the parity bit must equal this value
  localparam logic PS2_PARITY_ODD = 1'b1;

  function automatic logic parity_bad(input logic [7:0] data, input logic pbit);
    return ((^data) ^ pbit) != PS2_PARITY_ODD;
  endfunction

endpackage

// File: rtl/dsync.sv
// rtl/dsync.sv - two-flop synchroniser for an asynchronous single-bit input
module dsync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/ps2_sync_fifo.sv
// rtl/ps2_sync_fifo.sv - first-word-fall-through synchronous FIFO with occupancy count
module ps2_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             pop_ok, push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // a simultaneous pop frees the slot, so a push into a full FIFO is still taken
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end
endmodule

// File: rtl/ps2_rx_buf.sv
// rtl/ps2_rx_buf.sv - filtered PS/2 device-to-host receiver feeding a status-tagged FIFO
// Optional frame watchdog enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_rx_buf
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_data_i,
  input  logic       ps2_clk_i,
  output logic       ps2_clk_w,
  output logic       ps2_clk_o,
  input  logic       rx_en,
  input  logic       hold_req,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_parity_err,
  output logic       rd_frame_err,
  output logic       rd_vld,
  output logic       fifo_full,
  output logic       ovf,
  input  logic       ovf_clr,
  output logic       timeout_err,
  output logic       rcv_idle
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0] raw, syn, filt;
  logic       fclk, fdata, fclk_d, fneg;

  assign raw = {ps2_clk_i, ps2_data_i};

  for (genvar g = 0; g < 2; g++) begin : g_in
    logic          f;
    logic [FW-1:0] cnt;

    dsync #(.RST_VAL(1'b1)) u_dsync (.clk(clk), .rst(rst), .d(raw[g]), .q(syn[g]));

    // any sample agreeing with the filtered value restarts the run
    always_ff @(posedge clk) begin
      if (rst) begin
        f   <= 1'b1;
        cnt <= '0;
      end else if (syn[g] == f) begin
        cnt <= '0;
      end else if (cnt == FW'(FILTER_LEN - 1)) begin
        f   <= syn[g];
        cnt <= '0;
      end else begin
        cnt <= cnt + FW'(1);
      end
    end

    assign filt[g] = f;
  end

  assign fclk  = filt[1];
  assign fdata = filt[0];
  assign fneg  = fclk_d & ~fclk;

  always_ff @(posedge clk) begin
    if (rst) fclk_d <= 1'b1;
    else     fclk_d <= fclk;
  end

  ps2_state_e         state, state_n;
  logic [2:0]         bit_cnt;
  logic [7:0]         shreg;
  logic               perr;
  logic               abort, tmo, start, shift, par_lat, push, pop, fifo_empty;
  logic [ENTRY_W-1:0] wdata, head;
  logic [CW-1:0]      fifo_cnt;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic          fedge, in_frame;
  logic [TW-1:0] wd;

  assign fedge    = fclk_d ^ fclk;
  assign in_frame = (state == ST_DATA) || (state == ST_PARITY) || (state == ST_STOP);
  assign tmo      = in_frame && (wd == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || !in_frame || fedge) wd <= '0;
    else                           wd <= wd + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) timeout_err <= 1'b0;
    else     timeout_err <= tmo;
  end
`else
  assign tmo         = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign abort = !rx_en || tmo;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // HOLD still accepts a start bit: a device that ignores the inhibit is
  // decoded so that a push into a full FIFO is recorded as an overflow
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        if (hold_req || fifo_full)        state_n = ST_HOLD;
        else if (rx_en && fneg && !fdata) state_n = ST_DATA;
      end
      ST_DATA: begin
        if (abort)                        state_n = ST_IDLE;
        else if (fneg && bit_cnt == 3'd7) state_n = ST_PARITY;
      end
      ST_PARITY: begin
        if (abort)     state_n = ST_IDLE;
        else if (fneg) state_n = ST_STOP;
      end
      ST_STOP: begin
        if (abort)     state_n = ST_IDLE;
        else if (fneg) state_n = ST_IDLE;
      end
      ST_HOLD: begin
        if (rx_en && fneg && !fdata)      state_n = ST_DATA;
        else if (!hold_req && !fifo_full) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    start   = 1'b0;
    shift   = 1'b0;
    par_lat = 1'b0;
    push    = 1'b0;
    case (state)
      ST_IDLE, ST_HOLD: start   = (state_n == ST_DATA);
      ST_DATA:          shift   = fneg && !abort;
      ST_PARITY:        par_lat = fneg && !abort;
      ST_STOP:          push    = fneg && !abort;
      default: ;
    endcase
  end

  assign rcv_idle  = (state == ST_IDLE);
  assign ps2_clk_o = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
      perr    <= 1'b0;
    end else begin
      if (start) bit_cnt <= '0;
      if (shift) begin
        shreg   <= {fdata, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (par_lat) perr <= parity_bad(shreg, fdata);
    end
  end

  always_comb begin
    wdata                    = '0;
    wdata[DATA_MSB:DATA_LSB] = shreg;
    wdata[PERR_BIT]          = perr;
    wdata[FERR_BIT]          = ~fdata;
  end

  assign pop = rd_en & ~fifo_empty;

  ps2_sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign rd_vld        = ~fifo_empty;
  assign rd_data       = head[DATA_MSB:DATA_LSB];
  assign rd_parity_err = head[PERR_BIT];
  assign rd_frame_err  = head[FERR_BIT];

  always_ff @(posedge clk) begin
    if (rst) begin
      ps2_clk_w <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      ps2_clk_w <= (state == ST_HOLD);
      ovf       <= (ovf & ~ovf_clr) | (push && fifo_cnt == CW'(FIFO_DEPTH) && !pop);
    end
  end
endmodule
